arbitro_1: RTL

Four-to-one round-robin arbiter feeding the central FIFO that `arbitro_2` drains. Each cycle it selects one non-empty input FIFO (queues 0–3), pops one word from it, and pushes that word into the central FIFO one cycle later. It stalls while the central FIFO reports almost-full or the global state machine is not in its active state.

---
 rtl/arbitro_1.sv | 90 +++++++++
 1 files changed

// File: rtl/arbitro_1.sv
// Four-input round-robin arbiter that moves one word per cycle from the
// first-word-fall-through input FIFOs into the central FIFO.
module arbitro_1 #(
  parameter int          WIDTH        = 6,
  parameter logic [3:0]  ACTIVE_STATE = 4'b0100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       state,
  input  logic             empty0,
  input  logic             empty1,
  input  logic             empty2,
  input  logic             empty3,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic [WIDTH-1:0] data_in3,
  input  logic             almost_full,
  output logic             pop0,
  output logic             pop1,
  output logic             pop2,
  output logic             pop3,
  output logic             push,
  output logic [WIDTH-1:0] data_out
);

  logic [1:0]       ptr;
  logic [3:0]       empty;
  logic             enable;
  logic             found;
  logic [1:0]       g;
  logic [1:0]       idx;
  logic             grant;
  logic [3:0]       pop_v;
  logic [WIDTH-1:0] sel;

  assign empty  = {empty3, empty2, empty1, empty0};
  assign enable = (state == ACTIVE_STATE) && !almost_full && !reset;

  // First non-empty queue searching upward from ptr, wrapping mod 4
  always_comb begin
    found = 1'b0;
    g     = ptr;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && !empty[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
  end

  assign grant = enable && found;

  always_comb begin
    pop_v = 4'b0000;
    if (grant) pop_v[g] = 1'b1;
  end

  assign pop0 = pop_v[0];
  assign pop1 = pop_v[1];
  assign pop2 = pop_v[2];
  assign pop3 = pop_v[3];

  always_comb begin
    sel = data_in0;
    unique case (g)
      2'd0: sel = data_in0;
      2'd1: sel = data_in1;
      2'd2: sel = data_in2;
      2'd3: sel = data_in3;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= 2'd0;
      push     <= 1'b0;
      data_out <= '0;
    end else if (grant) begin
      ptr      <= g + 2'd1;
      push     <= 1'b1;
      data_out <= sel;
    end else begin
      push     <= 1'b0;
    end
  end

endmodule
